// File: rtl/fb_scan_reader.sv
//------------------------------------------------------------------------------
// Module      : fb_scan_reader
// Description : VGA timing generator that scans a pixel-replicated frame buffer
//               through a 3-stage pipeline (counters -> address -> colour).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_scan_reader #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int SCALE  = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] fb_data,
    output logic [14:0] a,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        in_vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SHIFT   = $clog2(SCALE);

    localparam logic [HW-1:0] c_h_last     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_vis      = HW'(H_VIS);
    localparam logic [HW-1:0] c_hs_start   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] c_hs_end     = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_v_last     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_vis      = VW'(V_VIS);
    localparam logic [VW-1:0] c_vs_start   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] c_vs_end     = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [14:0]   c_width      = 15'(WIDTH);

    // The frame buffer must exactly tile the visible area after replication.
    if ((WIDTH * SCALE != H_VIS) || (HEIGHT * SCALE != V_VIS) ||
        (WIDTH * HEIGHT > 32768) || ((1 << SHIFT) != SCALE)) begin : g_geometry_check
        $error("fb_scan_reader: inconsistent frame buffer geometry");
    end

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic          w_visible;
    logic          w_hsync;
    logic          w_vsync;
    logic [14:0]   w_row;
    logic [14:0]   w_col;
    logic [14:0]   w_addr;

    logic          r_vis_d1, r_vis_d2;
    logic          r_hs_d1,  r_hs_d2;
    logic          r_vs_d1,  r_vs_d2;
    logic [11:0]   r_rgb;
    logic          r_hsync;
    logic          r_vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_comb begin
        w_visible = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
        w_hsync   = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
        w_vsync   = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
        w_row     = 15'(r_v_cnt >> SHIFT);
        w_col     = 15'(r_h_cnt >> SHIFT);
        w_addr    = w_row * c_width + w_col;
    end

    // Stage 1: address issue; flags travel alongside so they stay aligned with RAM data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a        <= '0;
            r_vis_d1 <= 1'b0;
            r_hs_d1  <= 1'b1;
            r_vs_d1  <= 1'b1;
        end else begin
            a        <= w_visible ? w_addr : 15'd0;
            r_vis_d1 <= w_visible;
            r_hs_d1  <= w_hsync;
            r_vs_d1  <= w_vsync;
        end
    end

    // Stage 2: covers the synchronous RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vis_d2 <= 1'b0;
            r_hs_d2  <= 1'b1;
            r_vs_d2  <= 1'b1;
        end else begin
            r_vis_d2 <= r_vis_d1;
            r_hs_d2  <= r_hs_d1;
            r_vs_d2  <= r_vs_d1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= r_vis_d2 ? fb_data : 12'h000;
            r_hsync <= r_hs_d2;
            r_vsync <= r_vs_d2;
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign in_vblank   = (r_v_cnt >= c_v_vis);
    assign frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_fb_scan_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_fb_scan_reader
// Description : Bench for fb_scan_reader: full-size instance checked against a
//               vector table, reduced-geometry instance checked every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fb_scan_reader;

    localparam int SH_VIS = 64, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
    localparam int SV_VIS = 48, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
    localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
    localparam int SW = 16, SHT = 12, SSC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] f_fb, s_fb;
    logic [14:0] f_a, s_a;
    logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b;
    logic        f_hs, f_vs, f_vb, f_fs, s_hs, s_vs, s_vb, s_fs;

    fb_scan_reader u_full (
        .clk(clk), .reset_n(reset_n), .fb_data(f_fb), .a(f_a),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .hsync(f_hs), .vsync(f_vs),
        .in_vblank(f_vb), .frame_start(f_fs)
    );

    fb_scan_reader #(
        .WIDTH(SW), .HEIGHT(SHT), .SCALE(SSC),
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .fb_data(s_fb), .a(s_a),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs),
        .in_vblank(s_vb), .frame_start(s_fs)
    );

    // RAM models: mem[i] = i[11:0], one cycle read latency.
    always @(posedge clk) begin
        f_fb <= f_a[11:0];
        s_fb <= s_a[11:0];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    function automatic logic [14:0] s_addr(input int h, input int v);
        if (h < SH_VIS && v < SV_VIS) return 15'((v / SSC) * SW + h / SSC);
        return 15'd0;
    endfunction

    function automatic exp_t s_exp(input int h, input int v);
        exp_t        e;
        logic [14:0] ad;
        ad    = s_addr(h, v);
        e.rgb = ad[11:0];
        e.hs  = !(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC);
        e.vs  = !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC);
        return e;
    endfunction

    exp_t        q[$];
    int          sh = 0, sv = 0, rel_cyc = 0, gcyc = 0;
    logic [14:0] exp_a = '0;
    bit          sb_en = 1'b1;

    // Reduced-geometry scoreboard: expected outputs queued per position, popped 3 cycles later.
    initial begin
        exp_t d, blank;
        int   hs_run, vs_run, last_hs_fall, last_vs_fall, last_fs;
        logic prev_hs, prev_vs;
        blank = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
        hs_run = 0; vs_run = 0; last_hs_fall = -1; last_vs_fall = -1; last_fs = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        forever begin
            @(negedge clk);
            gcyc++;
            if (!reset_n) begin
                rel_cyc = 0; sh = 0; sv = 0; exp_a = '0;
                q.delete();
                q.push_back(blank);
                q.push_back(blank);
                hs_run = 0; vs_run = 0; last_hs_fall = -1; last_vs_fall = -1;
                last_fs = gcyc; prev_hs = 1'b1; prev_vs = 1'b1;
                if (sb_en) begin
                    chk("rst_a", s_a, 0);
                    chk("rst_rgb", {s_r, s_g, s_b}, 0);
                    chk("rst_hsync", s_hs, 1);
                    chk("rst_vsync", s_vs, 1);
                    chk("rst_vblank", s_vb, 0);
                    chk("rst_fstart", s_fs, 1);
                end
            end else begin
                rel_cyc++;
                if (sb_en) begin
                    q.push_back(s_exp(sh, sv));
                    exp_a = s_addr(sh, sv);
                    if (sh == SH_TOT - 1) begin
                        sh = 0;
                        sv = (sv == SV_TOT - 1) ? 0 : sv + 1;
                    end else begin
                        sh++;
                    end
                    d = q.pop_front();
                    chk("s_rgb", {s_r, s_g, s_b}, d.rgb);
                    chk("s_hsync", s_hs, d.hs);
                    chk("s_vsync", s_vs, d.vs);
                    chk("s_a", s_a, exp_a);
                    chk("s_vblank", s_vb, (sv >= SV_VIS) ? 1 : 0);
                    chk("s_fstart", s_fs, (sh == 0 && sv == 0) ? 1 : 0);
                    if (!s_hs) begin
                        if (prev_hs) begin
                            if (last_hs_fall >= 0) chk("hsync_period", gcyc - last_hs_fall, SH_TOT);
                            last_hs_fall = gcyc;
                        end
                        hs_run++;
                    end else if (!prev_hs) begin
                        chk("hsync_width", hs_run, SH_SYNC);
                        hs_run = 0;
                    end
                    if (!s_vs) begin
                        if (prev_vs) begin
                            if (last_vs_fall >= 0) chk("vsync_period", gcyc - last_vs_fall, SH_TOT * SV_TOT);
                            last_vs_fall = gcyc;
                        end
                        vs_run++;
                    end else if (!prev_vs) begin
                        chk("vsync_width", vs_run, SV_SYNC * SH_TOT);
                        vs_run = 0;
                    end
                    if (s_fs) begin
                        chk("frame_period", gcyc - last_fs, SH_TOT * SV_TOT);
                        last_fs = gcyc;
                    end
                    prev_hs = s_hs;
                    prev_vs = s_vs;
                end
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [14:0] a;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
    } vec_t;

    initial begin
        vec_t tbl[19];
        int   guard;
        tbl[0]  = '{0,    15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1,    15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3,    15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{5,    15'd1,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{6,    15'd1,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{7,    15'd1,   12'h001, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{10,   15'd2,   12'h001, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{11,   15'd2,   12'h002, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{640,  15'd159, 12'h09F, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{641,  15'd0,   12'h09F, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{644,  15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{658,  15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{659,  15'd0,   12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{754,  15'd0,   12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{755,  15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{3200, 15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{3201, 15'd160, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{3204, 15'd160, 12'h0A0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{3205, 15'd161, 12'h0A0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b1;

        // Full-size instance: table vectors indexed by cycles since reset release.
        for (int i = 0; i < 19; i++) begin
            guard = 0;
            while (rel_cyc != tbl[i].cyc && guard < 5000) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (rel_cyc != tbl[i].cyc) begin
                bound_fail("full_table_wait");
            end else begin
                chk($sformatf("full_a[%0d]", tbl[i].cyc), f_a, tbl[i].a);
                chk($sformatf("full_rgb[%0d]", tbl[i].cyc), {f_r, f_g, f_b}, tbl[i].rgb);
                chk($sformatf("full_hsync[%0d]", tbl[i].cyc), f_hs, tbl[i].hs);
                chk($sformatf("full_vsync[%0d]", tbl[i].cyc), f_vs, tbl[i].vs);
                chk($sformatf("full_vblank[%0d]", tbl[i].cyc), f_vb, tbl[i].vb);
                chk($sformatf("full_fstart[%0d]", tbl[i].cyc), f_fs, tbl[i].fs);
            end
        end

        // Asynchronous reset in the middle of a visible line of the second frame.
        guard = 0;
        while (!(rel_cyc > SH_TOT * SV_TOT && sh == 30 && sv == 20) && guard < 10000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!(sh == 30 && sv == 20)) bound_fail("mid_frame_wait");
        chk("pre_rst_rgb", {s_r, s_g, s_b}, 12'(((20 / SSC) * SW) + (27 / SSC)));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_a", s_a, 0);
        chk("mid_rst_rgb", {s_r, s_g, s_b}, 0);
        chk("mid_rst_hsync", s_hs, 1);
        chk("mid_rst_vsync", s_vs, 1);
        chk("mid_rst_fstart", s_fs, 1);
        chk("mid_rst_vblank", s_vb, 0);
        chk("mid_rst_full_a", f_a, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rel_rgb[%0d]", k), {s_r, s_g, s_b}, (k >= 7) ? 1 : 0);
            chk($sformatf("rel_full_rgb[%0d]", k), {f_r, f_g, f_b}, (k >= 7) ? 1 : 0);
        end

        // Two more reduced frames under the scoreboard.
        repeat (2 * SH_TOT * SV_TOT + 200) @(negedge clk);
        sb_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
